uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and issue sequencer that feeds the UART transmitter over its data/flag/busy handshake.
// Optional build macro UART_TX_FIFO_CRLF_EN: a 0x0A byte is sent as 0x0D followed by 0x0A.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                ovf_clr,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic [7:0]          tx_data,
  output logic                tx_flag,
  input  logic                tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [7:0]            head;
  logic                  accept;
  logic                  start;
  logic                  pop;

  // level only reaches 2^DEPTH_LOG2 when full, so its MSB is the full flag
  assign full   = level[DEPTH_LOG2];
  assign empty  = (level == '0);
  assign head   = mem[rd_ptr];
  assign accept = wr_en & ~full;
  assign start  = (state == IDLE) & ~empty & ~tx_busy;

`ifdef UART_TX_FIFO_CRLF_EN
  logic cr_sent;
  logic insert_cr;

  // a line feed at the head is first preceded by a carriage return, without popping
  assign insert_cr = start & (head == 8'h0A) & ~cr_sent;
  assign pop       = start & ~insert_cr;
`else
  assign pop = start;
`endif

  always_ff @(posedge CLK) begin
    if (RESET_N && accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // full is judged before any same-cycle pop, and a new overflow beats a clear
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= IDLE;
      tx_flag <= 1'b0;
      tx_data <= 8'h00;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ISSUE;
            tx_flag <= 1'b1;
`ifdef UART_TX_FIFO_CRLF_EN
            if (insert_cr) begin
              tx_data <= 8'h0D;
              cr_sent <= 1'b1;
            end else begin
              tx_data <= head;
              cr_sent <= 1'b0;
            end
`else
            tx_data <= head;
`endif
          end
        end
        ISSUE: begin
          if (tx_busy) begin
            state   <= WAIT;
            tx_flag <= 1'b0;
          end
        end
        WAIT: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          tx_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model compared every cycle, a simple
// transmitter model on the handshake, and directed scenarios with literal expectations.
module tb_uart_tx_fifo;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] tx_data;
  logic       tx_flag;
  logic       tx_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .tx_data(tx_data), .tx_flag(tx_flag), .tx_busy(tx_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transmitter model: samples flag when not busy, raises busy next cycle for wtime+1 cycles
  logic       hold_busy = 1'b0;
  int         wtime = 3;
  int         xcnt = 0;
  logic [7:0] tx_log[$];
  logic [7:0] exp_log[$];

  always @(posedge CLK) begin
    if (hold_busy) begin
      tx_busy <= 1'b1;
      xcnt    <= 0;
    end else if (!tx_busy && tx_flag === 1'b1) begin
      tx_busy <= 1'b1;
      xcnt    <= wtime;
      tx_log.push_back(tx_data);
    end else if (tx_busy) begin
      if (xcnt == 0) tx_busy <= 1'b0;
      else xcnt <= xcnt - 1;
    end
  end

  // reference model: byte queue plus handshake phase
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_flag = 1'b0, m_wait = 1'b0, m_crs = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         full_pre;
  bit         crlf;

  initial begin
`ifdef UART_TX_FIFO_CRLF_EN
    crlf = 1'b1;
`else
    crlf = 1'b0;
`endif
  end

  always @(posedge CLK) begin
    if (!RESET_N) begin
      mq.delete();
      m_ovf = 1'b0; m_flag = 1'b0; m_wait = 1'b0; m_crs = 1'b0; m_data = 8'h00;
    end else begin
      full_pre = (mq.size() == 16);
      if (!m_flag && !m_wait && mq.size() != 0 && !tx_busy) begin
        if (crlf && mq[0] == 8'h0A && !m_crs) begin
          m_data = 8'h0D;
          m_crs  = 1'b1;
        end else begin
          m_data = mq.pop_front();
          m_crs  = 1'b0;
        end
        m_flag = 1'b1;
      end else if (m_flag && tx_busy) begin
        m_flag = 1'b0;
        m_wait = 1'b1;
      end else if (m_wait && !tx_busy) begin
        m_wait = 1'b0;
      end
      if (wr_en && full_pre) begin
        m_ovf = 1'b1;
      end else begin
        if (wr_en) mq.push_back(wr_data);
        if (ovf_clr) m_ovf = 1'b0;
      end
    end
  end

  // per-cycle compare plus handshake timing monitor
  bit started = 1'b0;
  bit gap_en = 1'b0;
  bit fall_armed = 1'b0;
  logic prev_busy = 1'b0, prev_flag = 1'b0;
  int cyc = 0, fall_cyc = 0, rise_cyc = 0, gap_cnt = 0;

  always @(negedge CLK) begin
    if (started) begin
      check("level", level, mq.size());
      check("full", full, mq.size() == 16);
      check("empty", empty, mq.size() == 0);
      check("overflow", overflow, m_ovf);
      check("tx_flag", tx_flag, m_flag);
      check("tx_data", tx_data, m_data);
      if (gap_en) begin
        if (prev_busy && !tx_busy) begin
          fall_cyc   = cyc;
          fall_armed = (mq.size() != 0);
        end
        if (!prev_flag && tx_flag) begin
          rise_cyc = cyc;
          if (fall_armed) begin
            check("busy_fall_to_flag", cyc - fall_cyc, 2);
            gap_cnt++;
            fall_armed = 1'b0;
          end
        end
        if (prev_flag && !tx_flag) check("issue_len", cyc - rise_cyc, 2);
      end
      prev_busy = tx_busy;
      prev_flag = tx_flag;
      cyc++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(empty && !tx_flag && !tx_busy) && n < budget) begin
      step();
      n++;
    end
    check("wait_idle_timeout", n < budget, 1);
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, tx_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < tx_log.size(); i++)
      check(name, tx_log[i], exp_log[i]);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // release a held busy, then write on the exact cycle the FIFO pops
  task automatic pop_with_write(input logic [7:0] d);
    int n = 0;
    hold_busy = 1'b0;
    step();
    while (tx_busy && n < 20) begin
      step();
      n++;
    end
    check("release_timeout", n < 20, 1);
    write_byte(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
    step();
    started = 1'b1;
    step();
    RESET_N = 1'b1;
    @(negedge CLK);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_flag", tx_flag, 0);
    check("rst_tx_data", tx_data, 8'h00);

    // single byte: flag two edges after the write
    step();
    write_byte(8'h41);
    @(negedge CLK);
    check("t1_level_after_write", level, 1);
    check("t1_flag_after_write", tx_flag, 0);
    step();
    @(negedge CLK);
    check("t1_flag", tx_flag, 1);
    check("t1_data", tx_data, 8'h41);
    check("t1_level_after_issue", level, 0);
    wait_idle(200);
    exp_log = '{8'h41};
    check_log("t1_log");

    // back-to-back string
    tx_log.delete();
    gap_en = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 8'h48; step();
    wr_data = 8'h69; step();
    wr_data = 8'h21; step();
    wr_en = 1'b0;
    wait_idle(300);
    gap_en = 1'b0;
    exp_log = '{8'h48, 8'h69, 8'h21};
    check_log("t2_log");
    check("t2_gap_count", gap_cnt, 2);

    // fill while transmitter busy, overflow on 17th
    tx_log.delete();
    hold_busy = 1'b1;
    step(); step();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h60 + 8'(i);
      step();
      if (i == 15) begin
        @(negedge CLK);
        check("t3_full16", full, 1);
        check("t3_level16", level, 16);
        check("t3_no_ovf_yet", overflow, 0);
      end
    end
    wr_en = 1'b0;
    @(negedge CLK);
    check("t3_overflow", overflow, 1);
    check("t3_level_kept", level, 16);
    step();
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    @(negedge CLK);
    check("t3_ovf_cleared", overflow, 0);

    // write on the pop cycle at full: dropped
    pop_with_write(8'hEE);
    @(negedge CLK);
    check("t4_full_pop_ovf", overflow, 1);
    check("t4_full_pop_level", level, 15);
    wait_idle(2000);
    exp_log.delete();
    for (int i = 0; i < 16; i++) exp_log.push_back(8'h60 + 8'(i));
    check_log("t4_log");

    // write and pop in the same cycle at level 5
    tx_log.delete();
    step();
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    hold_busy = 1'b1;
    step(); step();
    for (int i = 0; i < 5; i++) write_byte(8'h80 + 8'(i));
    @(negedge CLK);
    check("t4_level5", level, 5);
    pop_with_write(8'h85);
    @(negedge CLK);
    check("t4_level5_kept", level, 5);
    check("t4_no_ovf", overflow, 0);
    wait_idle(500);
    exp_log = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
    check_log("t4b_log");

    // reset while waiting on the transmitter with 3 bytes queued
    tx_log.delete();
    wtime = 10;
    step();
    wr_en = 1'b1; wr_data = 8'hA0; step();
    wr_data = 8'hA1; step();
    wr_data = 8'hA2; step();
    wr_data = 8'hA3; step();
    wr_en = 1'b0;
    begin
      int n = 0;
      while (!(tx_busy && !tx_flag) && n < 20) begin
        step();
        n++;
      end
      check("t5_wait_timeout", n < 20, 1);
    end
    @(negedge CLK);
    check("t5_level3", level, 3);
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    @(negedge CLK);
    check("t5_level0", level, 0);
    check("t5_empty", empty, 1);
    check("t5_flag0", tx_flag, 0);
    wait_idle(100);
    step(); step();
    @(negedge CLK);
    check("t5_no_issue", tx_flag, 0);
    exp_log = '{8'hA0};
    check_log("t5_log");

    // line feed handling
    tx_log.delete();
    wtime = 3;
    step();
    write_byte(8'h41);
    write_byte(8'h0A);
    wait_idle(300);
`ifdef UART_TX_FIFO_CRLF_EN
    exp_log = '{8'h41, 8'h0D, 8'h0A};
`else
    exp_log = '{8'h41, 8'h0A};
`endif
    check_log("t6_log");

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
